lcd_hd44780_rx: RTL
===================

# lcd_hd44780_rx

Display-side responder for the HD44780-style 8-bit parallel LCD bus that our LCD controller drives (RS/RW/E/DATA). It decodes the command/data stream and maintains a 2×16 character mirror of DDRAM. It also emulates the module's busy timing and flags protocol violations. It serves as the bench/scoreboard target for the controller and as the character source for an on-chip display mirror.

## Interface
Parameters:
- CMD_CYCLES, 2000: busy duration after a data write or a short command (40 µs at 50 MHz).
- CLR_CYCLES, 82000: busy duration after Clear or Return Home (1.64 ms).
- MIN_E_HIGH, 12: minimum E-high width in clocks for a valid transfer.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous active-high reset
- i_lcd_rs  in  1  0 = command, 1 = data
- i_lcd_rw  in  1  0 = write, 1 = read
- i_lcd_e  in  1  enable strobe
- i_lcd_data  in  8  bus data
- i_rd_idx  in  5  mirror read index; 0–15 = line 1, 16–31 = line 2
- o_rd_char  out  8  character at i_rd_idx, registered
- o_ac  out  7  DDRAM address counter
- o_busy  out  1  emulated busy flag
- o_disp_on  out  1  display-on bit (D) from command 0x08–0x0F
- o_frame_tick  out  1  one-cycle pulse when a data write lands on address 0x4F
- o_err  out  3  sticky error bits: [0] E fall while busy, [1] E high shorter than MIN_E_HIGH, [2] RW=1 transfer

## Operation
- All bus inputs are registered once. E edges are detected on the registered copy.
- An E-high width counter runs while E is high and saturates at MIN_E_HIGH.
- RS, RW and DATA are latched on the E falling edge.
- A falling edge is rejected, with no state change, in these cases:
  - Width < MIN_E_HIGH: set err[1].
  - o_busy = 1: set err[0]; busy is not extended.
  - RW = 1: set err[2].
- A data write (RS = 1) does the following:
  - If the AC is in 0x00–0x0F, write the mirror at that index.
  - If the AC is in 0x40–0x4F, write the mirror at index AC − 0x40 + 16.
  - Any other AC value: no mirror write.
  - Then step the AC by ±1 according to I/D.
- Command decode (RS = 0), highest set bit wins:
  - 1xxxxxxx: AC = data[6:0].
  - 01xxxxxx (CGRAM address): ignored.
  - 001xxxxx (Function Set): accepted, no state change.
  - 0001xxxx (cursor/display shift): ignored.
  - 00001DCB: o_disp_on = D.
  - 000001IS: I/D = I; S is ignored.
  - 0000001x (Return Home): AC = 0.
  - 00000001 (Clear): fill all 32 cells with 0x20, AC = 0, I/D = 1.
- AC wrap follows 2-line mode:
  - Incrementing: 0x27 → 0x40, 0x67 → 0x00.
  - Decrementing: 0x00 → 0x67, 0x40 → 0x27.
- FSM states:
  - IDLE → EXEC on an accepted E fall.
  - EXEC → CLEAR for a Clear command; otherwise EXEC → BUSY.
  - CLEAR writes one cell per cycle, indices 0–31 (32 cycles), then → BUSY. o_busy stays high throughout.
  - BUSY → IDLE when the busy counter expires.

## Timing
- Reset values: mirror all 0x20, o_rd_char = 0x20, o_ac = 0, I/D = 1, o_busy = 0, o_disp_on = 0, o_frame_tick = 0, o_err = 0, FSM in IDLE.
- Latency from E fall on the pin:
  - Cycle +1: E registered.
  - Cycle +2: fall detected, EXEC.
  - Cycle +3: mirror, AC and flags updated; o_busy rises.
- o_busy stays high for exactly CMD_CYCLES, or CLR_CYCLES for Clear/Return Home, counted from its rising cycle. The CLEAR fill is included in that count.
- o_frame_tick is high in the same cycle as the mirror update.
- o_rd_char has 1-cycle latency. On a same-cycle read and write of the same cell, it returns the old value.
- Reset asserted mid-CLEAR or mid-BUSY: immediate return to reset values. A partial fill is discarded by the full reset.

## Structure
- Package lcd_pkg holds:
  - Opcode masks (CLR 0x01, HOME 0x02, ENTRY 0x04, DISP 0x08, FUNC 0x20, CGRAM 0x40, DDRAM 0x80).
  - Line base addresses 0x00 and 0x40, and line length 16.
  - Blank char 0x20 and the err bit indices.
- One sub-module, lcd_ddram_mirror:
  - 32×8 storage with one write port (index, char) and one registered read port.
  - AC-to-index mapping with a valid output.
  - Reset-to-blank.

## Test plan
- Init: 0x38, 0x0C, 0x06, 0x01 with E high 52 cycles and 2502-cycle gaps (extend to 100002 after 0x01) → o_disp_on = 1, o_err = 0, o_busy high 2000 / 2000 / 2000 / 82000 cycles.
- 0x80 then 16 × 0x4F → reads at indices 0–15 return 0x4F; o_ac = 0x10.
- 0xC0 then 16 × 0x20 with 0x4F last → exactly one o_frame_tick; index 31 reads 0x4F, index 16 reads 0x20; o_ac = 0x50.
- 5-cycle E pulse with data 0x41 → err[1] = 1, mirror and o_ac unchanged. A second E fall 100 cycles after a write → err[0] = 1, busy end time unchanged.
- 0x80, 0x04, write 0x41 → index 0 = 0x41, o_ac = 0x67. The next write leaves the mirror unchanged and sets o_ac = 0x66.
- Clear issued, rst pulsed 10 cycles into CLEAR → all outputs at reset values, all 32 cells read 0x20.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 bus responder: opcode masks, DDRAM line
// geometry, blank character, error bit positions and the 2-line AC stepper.
package lcd_pkg;

    localparam logic [7:0] OP_CLR   = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam int         LINE_LEN   = 16;

    // Last DDRAM address of each line in 2-line mode (40 cells per line)
    localparam logic [6:0] LINE1_LAST = 7'h27;
    localparam logic [6:0] LINE2_LAST = 7'h67;

    // Last visible cell of line 2; a data write here marks a finished frame
    localparam logic [6:0] FRAME_END_ADDR = LINE2_BASE + 7'(LINE_LEN - 1);

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    localparam int ERR_BUSY  = 0;
    localparam int ERR_SHORT = 1;
    localparam int ERR_READ  = 2;

    // Next address counter value, wrapping between the two lines like the real part
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (ac == LINE1_LAST)      nxt = LINE2_BASE;
            else if (ac == LINE2_LAST) nxt = LINE1_BASE;
            else                       nxt = ac + 7'd1;
        end else begin
            if (ac == LINE1_BASE)      nxt = LINE2_LAST;
            else if (ac == LINE2_BASE) nxt = LINE1_LAST;
            else                       nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_ddram_mirror.sv
// 2x16 character mirror of the visible DDRAM cells: one write port, one
// registered read port, and the AC-to-cell mapping used by data writes.
module lcd_ddram_mirror
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] ac,
    output logic [4:0] map_idx,
    output logic       map_valid,
    input  logic       wr_en,
    input  logic [4:0] wr_idx,
    input  logic [7:0] wr_char,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char
);

    logic [7:0] mem [0:31];
    logic [6:0] off1;
    logic [6:0] off2;

    assign off1 = ac - LINE1_BASE;
    assign off2 = ac - LINE2_BASE;

    // Map the address counter onto a visible cell; addresses off-screen are not mirrored
    always_comb begin
        map_idx   = 5'd0;
        map_valid = 1'b0;
        if (off1 < 7'(LINE_LEN)) begin
            map_idx   = {1'b0, off1[3:0]};
            map_valid = 1'b1;
        end else if (off2 < 7'(LINE_LEN)) begin
            map_idx   = {1'b1, off2[3:0]};
            map_valid = 1'b1;
        end
    end

    // Cell storage, blanked by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= BLANK_CHAR;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_char;
        end
    end

    // Registered read; a same-cycle write to the same cell returns the old value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_char <= BLANK_CHAR;
        else     rd_char <= mem[rd_idx];
    end

endmodule

// File: rtl/lcd_hd44780_rx.sv
// Display-side HD44780 8-bit bus responder: decodes commands/data on E falls,
// keeps the DDRAM mirror and address counter, emulates busy time and flags
// protocol violations.
module lcd_hd44780_rx
    import lcd_pkg::*;
#(
    parameter int CMD_CYCLES = 2000,
    parameter int CLR_CYCLES = 82000,
    parameter int MIN_E_HIGH = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic       i_lcd_e,
    input  logic [7:0] i_lcd_data,
    input  logic [4:0] i_rd_idx,
    output logic [7:0] o_rd_char,
    output logic [6:0] o_ac,
    output logic       o_busy,
    output logic       o_disp_on,
    output logic       o_frame_tick,
    output logic [2:0] o_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_BUSY  = 2'd3;

    logic        rs_q, rw_q, e_q, e_prev;
    logic [7:0]  data_q;
    logic        rs_qq, rw_qq;
    logic [7:0]  data_qq;
    logic [15:0] e_width;
    logic        e_fall, width_ok, accept;

    logic [1:0]  state;
    logic        cmd_rs;
    logic [7:0]  cmd_data;
    logic [31:0] busy_cnt;
    logic [4:0]  fill_idx;
    logic        id_inc;

    logic [4:0]  map_idx;
    logic        map_valid;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [7:0]  wr_char;

    // Register the bus once, plus a second stage holding RS/RW/DATA as seen while E was still high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            e_q     <= 1'b0;
            e_prev  <= 1'b0;
            data_q  <= 8'h00;
            rs_qq   <= 1'b0;
            rw_qq   <= 1'b0;
            data_qq <= 8'h00;
        end else begin
            rs_q    <= i_lcd_rs;
            rw_q    <= i_lcd_rw;
            e_q     <= i_lcd_e;
            e_prev  <= e_q;
            data_q  <= i_lcd_data;
            rs_qq   <= rs_q;
            rw_qq   <= rw_q;
            data_qq <= data_q;
        end
    end

    // E-high width, saturating at the minimum valid width and cleared while E is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_width <= 16'd0;
        end else if (!e_q) begin
            e_width <= 16'd0;
        end else if (e_width < 16'(MIN_E_HIGH)) begin
            e_width <= e_width + 16'd1;
        end
    end

    assign e_fall   = e_prev & ~e_q;
    assign width_ok = (e_width >= 16'(MIN_E_HIGH));
    assign accept   = e_fall && width_ok && !rw_qq && (state == ST_IDLE);

    // Flag rejected transfers; any non-idle state counts as busy, including the EXEC cycle before o_busy rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_err <= 3'b000;
        end else if (e_fall) begin
            if (!width_ok)          o_err[ERR_SHORT] <= 1'b1;
            if (state != ST_IDLE)   o_err[ERR_BUSY]  <= 1'b1;
            if (rw_qq)              o_err[ERR_READ]  <= 1'b1;
        end
    end

    // Transfer FSM: latch, execute, optional clear fill, then count down busy time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cmd_rs       <= 1'b0;
            cmd_data     <= 8'h00;
            busy_cnt     <= 32'd0;
            fill_idx     <= 5'd0;
            id_inc       <= 1'b1;
            o_ac         <= 7'd0;
            o_busy       <= 1'b0;
            o_disp_on    <= 1'b0;
            o_frame_tick <= 1'b0;
        end else begin
            o_frame_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_rs   <= rs_qq;
                        cmd_data <= data_qq;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    o_busy   <= 1'b1;
                    state    <= ST_BUSY;
                    busy_cnt <= 32'(CMD_CYCLES - 1);
                    if (cmd_rs) begin
                        if (o_ac == FRAME_END_ADDR) o_frame_tick <= 1'b1;
                        o_ac <= ac_step(o_ac, id_inc);
                    end else if ((cmd_data & OP_DDRAM) != 8'h00) begin
                        o_ac <= cmd_data[6:0];
                    end else if ((cmd_data & (OP_CGRAM | OP_FUNC | OP_SHIFT)) != 8'h00) begin
                        // CGRAM address, function set and shift are accepted without effect
                    end else if ((cmd_data & OP_DISP) != 8'h00) begin
                        o_disp_on <= cmd_data[2];
                    end else if ((cmd_data & OP_ENTRY) != 8'h00) begin
                        id_inc <= cmd_data[1];
                    end else if ((cmd_data & OP_HOME) != 8'h00) begin
                        o_ac     <= 7'd0;
                        busy_cnt <= 32'(CLR_CYCLES - 1);
                    end else if ((cmd_data & OP_CLR) != 8'h00) begin
                        o_ac     <= 7'd0;
                        id_inc   <= 1'b1;
                        fill_idx <= 5'd0;
                        busy_cnt <= 32'(CLR_CYCLES - 1);
                        state    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    // The fill runs inside the busy window, so the counter keeps running here
                    if (busy_cnt != 32'd0) busy_cnt <= busy_cnt - 32'd1;
                    fill_idx <= fill_idx + 5'd1;
                    if (fill_idx == 5'd31) state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (busy_cnt == 32'd0) begin
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        busy_cnt <= busy_cnt - 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Mirror write port: data writes to visible cells, or the blank fill during CLEAR
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = map_idx;
        wr_char = cmd_data;
        if (state == ST_EXEC && cmd_rs && map_valid) begin
            wr_en = 1'b1;
        end else if (state == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = fill_idx;
            wr_char = BLANK_CHAR;
        end
    end

    lcd_ddram_mirror u_mirror (
        .clk       (clk),
        .rst       (rst),
        .ac        (o_ac),
        .map_idx   (map_idx),
        .map_valid (map_valid),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_char   (wr_char),
        .rd_idx    (i_rd_idx),
        .rd_char   (o_rd_char)
    );

endmodule
